// File: rtl/vga_pkg.sv
// Shared frame-buffer widths and the BRAM port grant encoding.
// Used by the arbiter and its write buffer.
package vga_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 12;

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_READ  = 2'd1,
        GNT_WRITE = 2'd2
    } grant_e;

endpackage

// File: rtl/bram_wr_fifo.sv
// Camera write buffer: synchronous FIFO holding {addr,data} as one word.
// Count, full and empty are registered; ready is registered separately.
module bram_wr_fifo
    import vga_pkg::*;
#(
    parameter int AW    = 16,
    parameter int DW    = 12,
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [AW-1:0] head_addr_o,
    output logic [DW-1:0] head_data_o,
    output logic          empty_o,
    output logic          ready_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW+DW-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, empty_q, rdy_q;
    logic             push_ok, pop_ok;

    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & ~empty_q;

    // Occupancy next state; push and pop together leave it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointers, count and flags; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            rdy_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == FULL_CNT);
            empty_q <= (cnt_d == '0);
            rdy_q   <= (cnt_d != FULL_CNT);
        end
    end

    // Entry storage; address and data are written as a single word.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= {addr_i, data_i};
    end

    assign {head_addr_o, head_data_o} = mem_q[rd_ptr_q];
    assign empty_o = empty_q;
    assign ready_o = rdy_q;

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between VGA reads and buffered camera writes.
// Reads have strict priority and a fixed 3-cycle latency.
module bram_port_arbiter #(
    parameter int ADDR_W      = vga_pkg::ADDR_W,
    parameter int DATA_W      = vga_pkg::DATA_W,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic              CLK_25_I,
    input  logic              RST_N_I,
    input  logic              RD_REQ_I,
    input  logic [ADDR_W-1:0] RD_ADDR_I,
    output logic [DATA_W-1:0] RD_DATA_O,
    output logic              RD_VALID_O,
    input  logic              WR_REQ_I,
    input  logic [ADDR_W-1:0] WR_ADDR_I,
    input  logic [DATA_W-1:0] WR_DATA_I,
    output logic              WR_READY_O,
    input  logic              OVF_CLR_I,
    output logic              OVF_O,
    output logic              BRAM_EN_O,
    output logic              BRAM_WE_O,
    output logic [ADDR_W-1:0] BRAM_ADDR_O,
    output logic [DATA_W-1:0] BRAM_WDATA_O,
    input  logic [DATA_W-1:0] BRAM_RDATA_I
);
    import vga_pkg::*;

    logic              fifo_rdy, fifo_empty;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              wr_push, wr_drop, wr_pop;

    grant_e            state_q, state_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_data_q, cmd_data_d;

    logic              en_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_s2_q, rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ovf_q, ovf_d;

    assign wr_push = WR_REQ_I & fifo_rdy;
    assign wr_drop = WR_REQ_I & ~fifo_rdy;
    assign wr_pop  = ~RD_REQ_I & ~fifo_empty;

    bram_wr_fifo #(
        .AW    (ADDR_W),
        .DW    (DATA_W),
        .DEPTH (WFIFO_DEPTH)
    ) u_wr_fifo (
        .clk_i       (CLK_25_I),
        .rst_n_i     (RST_N_I),
        .push_i      (wr_push),
        .addr_i      (WR_ADDR_I),
        .data_i      (WR_DATA_I),
        .pop_i       (wr_pop),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .empty_o     (fifo_empty),
        .ready_o     (fifo_rdy)
    );

    // Grant decision: read wins, else pop the write head, else idle.
    always_comb begin
        state_d    = GNT_IDLE;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        unique case (1'b1)
            RD_REQ_I: begin
                state_d    = GNT_READ;
                cmd_addr_d = RD_ADDR_I;
            end
            wr_pop: begin
                state_d    = GNT_WRITE;
                cmd_addr_d = head_addr;
                cmd_data_d = head_data;
            end
            default: ;
        endcase
    end

    // Grant register with the command it carries.
    always_ff @(posedge CLK_25_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q    <= GNT_IDLE;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
        end
    end

    // Registered BRAM port; address and wdata hold while idle.
    always_ff @(posedge CLK_25_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            en_q <= (state_q != GNT_IDLE);
            we_q <= (state_q == GNT_WRITE);
            if (state_q != GNT_IDLE)  addr_q  <= cmd_addr_q;
            if (state_q == GNT_WRITE) wdata_q <= cmd_data_q;
        end
    end

    // Read return: track the BRAM latency, then capture the pixel.
    always_ff @(posedge CLK_25_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            rd_s2_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rd_s2_q  <= en_q & ~we_q;
            rvalid_q <= rd_s2_q;
            if (rd_s2_q) rdata_q <= BRAM_RDATA_I;
        end
    end

    // Sticky overflow: a drop outranks a clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_drop) begin
            ovf_d = 1'b1;
        end else if (OVF_CLR_I) begin
            ovf_d = 1'b0;
        end
    end

    // Overflow flag register.
    always_ff @(posedge CLK_25_I or negedge RST_N_I) begin
        if (!RST_N_I) ovf_q <= 1'b0;
        else          ovf_q <= ovf_d;
    end

    assign RD_DATA_O    = rdata_q;
    assign RD_VALID_O   = rvalid_q;
    assign WR_READY_O   = fifo_rdy;
    assign OVF_O        = ovf_q;
    assign BRAM_EN_O    = en_q;
    assign BRAM_WE_O    = we_q;
    assign BRAM_ADDR_O  = addr_q;
    assign BRAM_WDATA_O = wdata_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a queue scoreboard.
// BRAM model returns data equal to the low address bits.
module tb_bram_port_arbiter;

    logic        clk;
    logic        RST_N_I;
    logic        RD_REQ_I;
    logic [15:0] RD_ADDR_I;
    logic [11:0] RD_DATA_O;
    logic        RD_VALID_O;
    logic        WR_REQ_I;
    logic [15:0] WR_ADDR_I;
    logic [11:0] WR_DATA_I;
    logic        WR_READY_O;
    logic        OVF_CLR_I;
    logic        OVF_O;
    logic        BRAM_EN_O;
    logic        BRAM_WE_O;
    logic [15:0] BRAM_ADDR_O;
    logic [11:0] BRAM_WDATA_O;
    logic [11:0] bram_rdata;

    bram_port_arbiter #(
        .ADDR_W      (16),
        .DATA_W      (12),
        .WFIFO_DEPTH (4)
    ) dut (
        .CLK_25_I     (clk),
        .RST_N_I      (RST_N_I),
        .RD_REQ_I     (RD_REQ_I),
        .RD_ADDR_I    (RD_ADDR_I),
        .RD_DATA_O    (RD_DATA_O),
        .RD_VALID_O   (RD_VALID_O),
        .WR_REQ_I     (WR_REQ_I),
        .WR_ADDR_I    (WR_ADDR_I),
        .WR_DATA_I    (WR_DATA_I),
        .WR_READY_O   (WR_READY_O),
        .OVF_CLR_I    (OVF_CLR_I),
        .OVF_O        (OVF_O),
        .BRAM_EN_O    (BRAM_EN_O),
        .BRAM_WE_O    (BRAM_WE_O),
        .BRAM_ADDR_O  (BRAM_ADDR_O),
        .BRAM_WDATA_O (BRAM_WDATA_O),
        .BRAM_RDATA_I (bram_rdata)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial bram_rdata = '0;
    always @(posedge clk) begin
        if (BRAM_EN_O && !BRAM_WE_O) bram_rdata <= BRAM_ADDR_O[11:0];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [11:0] d;
    } rd_exp_t;

    typedef struct {
        int          due;
        logic [15:0] a;
        logic [11:0] d;
    } wr_exp_t;

    rd_exp_t rdq[$];
    wr_exp_t wrq[$];
    int      n_vec = 0;
    int      n_bad = 0;
    logic    track = 1'b1;
    logic [11:0] last_rd = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: pop expectations whenever the DUT presents a result.
    always @(negedge clk) begin
        rd_exp_t re;
        wr_exp_t we;
        if (!RST_N_I) begin
            last_rd = '0;
        end else begin
            if (RD_VALID_O) begin
                if (rdq.size() == 0) begin
                    chk("rd_unexpected", 32'(RD_VALID_O), 0);
                end else begin
                    re = rdq.pop_front();
                    chk("rd_data", 32'(RD_DATA_O), 32'(re.d));
                    chk("rd_cycle", cyc, re.due);
                    last_rd = re.d;
                end
            end else begin
                chk("rd_hold", 32'(RD_DATA_O), 32'(last_rd));
            end
            if (BRAM_EN_O && BRAM_WE_O) begin
                if (wrq.size() == 0) begin
                    chk("we_unexpected", 32'(BRAM_WE_O), 0);
                end else begin
                    we = wrq.pop_front();
                    chk("wr_addr", 32'(BRAM_ADDR_O), 32'(we.a));
                    chk("wr_data", 32'(BRAM_WDATA_O), 32'(we.d));
                    if (we.due >= 0) chk("wr_cycle", cyc, we.due);
                end
            end
        end
    end

    // One cycle of stimulus, called at 1 time unit after a rising edge.
    task automatic step(input logic rd, input logic [15:0] ra,
                        input logic wr, input logic [15:0] wa,
                        input logic [11:0] wd, input logic acc,
                        input int wlat, input logic clr);
        RD_REQ_I  = rd;
        RD_ADDR_I = ra;
        WR_REQ_I  = wr;
        WR_ADDR_I = wa;
        WR_DATA_I = wd;
        OVF_CLR_I = clr;
        if (wr) chk("wr_ready", 32'(WR_READY_O), 32'(acc));
        if (track && rd) rdq.push_back('{due: cyc + 4, d: ra[11:0]});
        if (track && wr && acc) begin
            wrq.push_back('{due: (wlat >= 0) ? cyc + 1 + wlat : -1,
                            a: wa, d: wd});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, -1, 0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_rvalid"}, 32'(RD_VALID_O), 0);
        chk({nm, "_rdata"}, 32'(RD_DATA_O), 0);
        chk({nm, "_en"}, 32'(BRAM_EN_O), 0);
        chk({nm, "_we"}, 32'(BRAM_WE_O), 0);
        chk({nm, "_addr"}, 32'(BRAM_ADDR_O), 0);
        chk({nm, "_wdata"}, 32'(BRAM_WDATA_O), 0);
        chk({nm, "_ready"}, 32'(WR_READY_O), 0);
        chk({nm, "_ovf"}, 32'(OVF_O), 0);
    endtask

    initial begin
        RST_N_I   = 1'b0;
        RD_REQ_I  = 1'b0;
        RD_ADDR_I = '0;
        WR_REQ_I  = 1'b0;
        WR_ADDR_I = '0;
        WR_DATA_I = '0;
        OVF_CLR_I = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");
        RST_N_I = 1'b1;
        #1;
        chk("rdy_before_edge", 32'(WR_READY_O), 0);
        @(posedge clk);
        #1;
        chk("rdy_after_edge", 32'(WR_READY_O), 1);

        // Back-to-back reads of 0x0000..0x0009
        for (int i = 0; i < 10; i++) step(1, 16'(i), 0, 0, 0, 0, -1, 0);
        idle(6);

        // Two writes, no reads: WE two cycles after acceptance
        step(0, 0, 1, 16'h0100, 12'hABC, 1, 2, 0);
        step(0, 0, 1, 16'h0101, 12'h123, 1, 2, 0);
        idle(5);
        chk("ovf_after_writes", 32'(OVF_O), 0);

        // Reads hold the port for 20 cycles; writes 5 and 6 dropped
        for (int i = 0; i < 20; i++) begin
            step(1, 16'h0020 + 16'(i), i < 6, 16'h0200 + 16'(i),
                 12'h300 + 12'(i), i < 4, 21, 0);
            if (i == 4) chk("ovf_set_on_drop", 32'(OVF_O), 1);
        end
        idle(8);
        chk("ovf_sticky", 32'(OVF_O), 1);

        // Clear coinciding with a drop keeps the flag; lone clear drops it
        for (int i = 0; i < 4; i++) begin
            step(1, 16'h0040 + 16'(i), 1, 16'h0400 + 16'(i),
                 12'h040 + 12'(i), 1, 7, 0);
        end
        step(1, 16'h0044, 1, 16'h0404, 12'h444, 0, -1, 1);
        chk("ovf_set_wins", 32'(OVF_O), 1);
        step(1, 16'h0045, 0, 0, 0, 0, -1, 1);
        chk("ovf_cleared", 32'(OVF_O), 0);
        idle(8);

        // Alternating reads with a continuous write stream
        for (int i = 0; i < 12; i++) begin
            step(i % 2 == 0, 16'h0060 + 16'(i), i < 6,
                 16'h0600 + 16'(i), 12'h600 + 12'(i), 1, -1, 0);
        end
        idle(10);
        chk("ovf_after_alt", 32'(OVF_O), 0);

        // Reset with three reads in flight and two buffered writes
        track = 1'b0;
        step(1, 16'h0070, 1, 16'h0700, 12'h700, 1, -1, 0);
        step(1, 16'h0071, 1, 16'h0701, 12'h701, 1, -1, 0);
        step(1, 16'h0072, 0, 0, 0, 0, -1, 0);
        RD_REQ_I = 1'b0;
        RST_N_I  = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        RST_N_I = 1'b1;
        #1;
        chk("midrst_rdy_low", 32'(WR_READY_O), 0);
        @(posedge clk);
        #1;
        chk("midrst_rdy_high", 32'(WR_READY_O), 1);
        track = 1'b1;
        idle(8);

        chk("rd_queue_drained", rdq.size(), 0);
        chk("wr_queue_drained", wrq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning frame-buffer address width.
REQ-002 The block SHALL have parameter DATA_W, default 12, meaning pixel width {R[3:0],G[3:0],B[3:0]}.
REQ-003 The block SHALL have parameter WFIFO_DEPTH, default 4, meaning write-buffer entries (power of two, >=2).
REQ-004 The block SHALL have port CLK_25_I, input, 1, meaning the single 25 MHz clock.
REQ-005 The block SHALL have port RST_N_I, input, 1, meaning reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port RD_REQ_I, input, 1, meaning VGA pixel read request.
REQ-007 The block SHALL have port RD_ADDR_I, input, ADDR_W, meaning the VGA read address.
REQ-008 The block SHALL have port RD_DATA_O, output, DATA_W, meaning the returned pixel.
REQ-009 The block SHALL have port RD_VALID_O, output, 1, meaning RD_DATA_O is valid.
REQ-010 The block SHALL have port WR_REQ_I, input, 1, meaning camera pixel write request.
REQ-011 The block SHALL have port WR_ADDR_I, input, ADDR_W, meaning the camera write address.
REQ-012 The block SHALL have port WR_DATA_I, input, DATA_W, meaning the camera write pixel.
REQ-013 The block SHALL have port WR_READY_O, output, 1, meaning the write buffer can accept a request.
REQ-014 The block SHALL have port OVF_CLR_I, input, 1, meaning clear the sticky overflow flag.
REQ-015 The block SHALL have port OVF_O, output, 1, meaning the sticky flag that a write was dropped.
REQ-016 The block SHALL have ports BRAM_EN_O, BRAM_WE_O (outputs, 1), BRAM_ADDR_O (output, ADDR_W), BRAM_WDATA_O (output, DATA_W) and BRAM_RDATA_I (input, DATA_W), meaning the single-port BRAM with 1-cycle read latency.

Function
REQ-017 Grant is evaluated each cycle with these states: IDLE (no command), READ, WRITE; reads have strict priority.
REQ-018 RD_REQ_I=1 at edge N SHALL drive the registered BRAM port at N+1 with EN=1, WE=0, ADDR=RD_ADDR_I.
REQ-019 The read pixel SHALL appear on RD_DATA_O with RD_VALID_O=1 at N+3, a fixed latency of 3 for every read, back-to-back at one per cycle.
REQ-020 A write SHALL be accepted into the FIFO when WR_REQ_I=1 and WR_READY_O=1 at the same edge.
REQ-021 WR_REQ_I=1 with WR_READY_O=0 SHALL drop the write and set OVF_O at the next edge.
REQ-022 When RD_REQ_I=0 and the FIFO is non-empty at edge N, the head SHALL be popped and the port driven at N+1 with EN=1, WE=1, and the head ADDR/WDATA.
REQ-023 With neither a read nor a pending write, the port SHALL be driven with EN=0 and WE=0; ADDR and WDATA hold their last value.
REQ-024 The FIFO SHALL preserve write order, and the address and data of an entry SHALL never be split.
REQ-025 WR_READY_O SHALL be registered and equal (count_next != WFIFO_DEPTH); there is no pass-through when full, even with a same-cycle pop.
REQ-026 A simultaneous push and pop on a non-full FIFO SHALL leave the count unchanged.
REQ-027 Pointers SHALL wrap modulo WFIFO_DEPTH.
REQ-028 OVF_O SHALL clear on OVF_CLR_I=1; if a set and a clear occur in the same cycle, set wins.
REQ-029 RD_DATA_O SHALL hold its last value when RD_VALID_O=0.

Reset
REQ-030 RST_N_I low SHALL asynchronously force these outputs to 0: RD_VALID_O, RD_DATA_O, BRAM_EN_O, BRAM_WE_O, BRAM_ADDR_O, BRAM_WDATA_O, WR_READY_O and OVF_O.
REQ-031 Reset SHALL empty the FIFO and discard in-flight reads, with no RD_VALID_O after reset for reads issued before it.
REQ-032 WR_READY_O SHALL rise at the first edge after RST_N_I deasserts.

Structure
REQ-033 ADDR_W, DATA_W and the grant enum (IDLE/READ/WRITE) SHALL live in shared package vga_pkg.
REQ-034 The write buffer SHALL be sub-module bram_wr_fifo (synchronous FIFO, registered count, full/empty flags).

Verification
REQ-035 Reads to 0x0000..0x0009 back-to-back with BRAM preloaded with data=addr SHALL give RD_VALID_O for 10 cycles starting 3 cycles after the first request, with RD_DATA_O=0x000..0x009.
REQ-036 Writes (0x0100,0xABC) and (0x0101,0x123) with no reads SHALL drive BRAM_WE_O pulses in order, each 2 cycles after acceptance, with OVF_O=0.
REQ-037 RD_REQ_I held high for 20 cycles while 6 writes are offered SHALL give WR_READY_O=0 after the 4th write, drop writes 5 and 6, set OVF_O=1 and issue no WE until RD_REQ_I falls; then the 4 writes drain in order.
REQ-038 Alternating RD_REQ_I 1/0 with a continuous write stream SHALL give reads a fixed latency of 3 and writes only in read-free slots.
REQ-039 Asserting RST_N_I low mid-stream with 3 reads in flight and 2 FIFO entries SHALL make all outputs 0 immediately, produce no RD_VALID_O afterwards and raise WR_READY_O 1 cycle after release.
REQ-040 OVF_O=1 with OVF_CLR_I pulsed in the same cycle as a new drop SHALL leave OVF_O at 1, and a clear pulse alone SHALL return it to 0.
